// File: rtl/package_project_typedefs.sv
// rtl/package_project_typedefs.sv - shared pipeline control types for the execute stage
package package_project_typedefs;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_DIVU = 4'd11,
        ALU_REMU = 4'd12
    } AluOp;

    typedef enum logic [2:0] {
        JUMP_BRANCH_NO = 3'd0,
        JUMP           = 3'd1,
        JUMP_ALR       = 3'd2,
        BRANCH_EQ      = 3'd3,
        BRANCH_NE      = 3'd4,
        BRANCH_LT      = 3'd5,
        BRANCH_GE      = 3'd6,
        BRANCH_LTU     = 3'd7
    } JumpBranchControl;

    typedef enum logic [1:0] {
        DATA_MEM_NO_WR   = 2'd0,
        DATA_MEM_WR_BYTE = 2'd1,
        DATA_MEM_WR_HALF = 2'd2,
        DATA_MEM_WR_WORD = 2'd3
    } DataMemWrControl;

    function automatic logic is_muldiv(AluOp op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/execute_muldiv.sv
// rtl/execute_muldiv.sv - iterative shift-add multiplier / restoring divider, one step per cycle
module execute_muldiv
    import package_project_typedefs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  AluOp             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    logic             state;
    logic [CW-1:0]    count;
    AluOp             op_q;
    // acc: product or partial remainder; opa: multiplicand or dividend/quotient; opb: multiplier or divisor
    logic [WIDTH-1:0] acc, opa, opb;
    logic [WIDTH-1:0] acc_n, opa_n, diff;
    logic [WIDTH:0]   sh;
    logic             ge;

    always_comb begin
        sh   = {acc, opa[WIDTH-1]};
        ge   = (sh >= {1'b0, opb});
        diff = sh[WIDTH-1:0] - opb;
        if (op_q == ALU_MUL) begin
            acc_n = acc + (opb[0] ? opa : '0);
            opa_n = opa << 1;
        end else begin
            acc_n = ge ? diff : sh[WIDTH-1:0];
            opa_n = {opa[WIDTH-2:0], ge};
        end
    end

    assign busy   = (state == BUSY);
    assign done   = busy && (count == LAST);
    assign result = (op_q == ALU_DIVU) ? opa_n : acc_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
            op_q  <= ALU_ADD;
            acc   <= '0;
            opa   <= '0;
            opb   <= '0;
        end else if (abort) begin
            state <= IDLE;
            count <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                state <= BUSY;
                count <= '0;
                op_q  <= op;
                acc   <= '0;
                opa   <= a;
                opb   <= b;
            end
        end else begin
            acc   <= acc_n;
            opa   <= opa_n;
            if (op_q == ALU_MUL)
                opb <= opb >> 1;
            count <= count + 1'b1;
            if (done) begin
                state <= IDLE;
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/stage_execute.sv
// rtl/stage_execute.sv - EX stage: ALU, branch target, EX/MEM register; MULDIV_EN adds the iterative unit
module stage_execute
    import package_project_typedefs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] pc,
    input  AluOp             alu_op,
    input  logic             alu_src_imm,
    input  logic             valid_in,
    input  logic             flush,
    input  logic [4:0]       reg_file_wr_addr_in,
    input  JumpBranchControl jump_branch_signal_in,
    input  DataMemWrControl  data_mem_wr_en_in,
    output logic [WIDTH-1:0] alu_result_out,
    output logic             zero,
    output logic [WIDTH-1:0] jump_branch_addr_out,
    output logic [WIDTH-1:0] data_mem_wr_data,
    output logic [4:0]       reg_file_wr_addr_out,
    output JumpBranchControl jump_branch_signal,
    output DataMemWrControl  data_mem_wr_en,
    output logic             valid_out,
    output logic             stall_out
);

    logic [WIDTH-1:0] op_b, alu_res, jb_addr, result_sel;
    logic [4:0]       shamt;
    logic             issue, fire;

    always_comb begin
        op_b  = alu_src_imm ? imm : rs2_data;
        shamt = op_b[4:0];
        case (alu_op)
            ALU_ADD:  alu_res = rs1_data + op_b;
            ALU_SUB:  alu_res = rs1_data - op_b;
            ALU_AND:  alu_res = rs1_data & op_b;
            ALU_OR:   alu_res = rs1_data | op_b;
            ALU_XOR:  alu_res = rs1_data ^ op_b;
            ALU_SLL:  alu_res = rs1_data << shamt;
            ALU_SRL:  alu_res = rs1_data >> shamt;
            ALU_SRA:  alu_res = WIDTH'($signed(rs1_data) >>> shamt);
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(rs1_data) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (rs1_data < op_b)};
            default:  alu_res = '0;
        endcase
        jb_addr = (jump_branch_signal_in == JUMP_ALR)
                ? ((rs1_data + imm) & ~{{(WIDTH-1){1'b0}}, 1'b1})
                : (pc + imm);
    end

`ifdef MULDIV_EN
    logic             md_busy, md_done, md_start;
    logic [WIDTH-1:0] md_result;

    assign md_start = valid_in && is_muldiv(alu_op) && !md_busy && !flush;

    execute_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (md_start),
        .abort   (flush),
        .op      (alu_op),
        .a       (rs1_data),
        .b       (op_b),
        .busy    (md_busy),
        .done    (md_done),
        .result  (md_result)
    );

    // Upstream keeps presenting the multi-cycle op until the completion cycle
    assign stall_out  = reset_n && ((valid_in && is_muldiv(alu_op) && !md_busy) || (md_busy && !md_done));
    assign issue      = md_busy ? md_done : (valid_in && !is_muldiv(alu_op));
    assign result_sel = md_busy ? md_result : alu_res;
`else
    assign stall_out  = 1'b0;
    assign issue      = valid_in;
    assign result_sel = alu_res;
`endif

    assign fire = issue && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_result_out       <= '0;
            zero                 <= 1'b0;
            jump_branch_addr_out <= '0;
            data_mem_wr_data     <= '0;
            reg_file_wr_addr_out <= '0;
            jump_branch_signal   <= JUMP_BRANCH_NO;
            data_mem_wr_en       <= DATA_MEM_NO_WR;
            valid_out            <= 1'b0;
        end else begin
            alu_result_out       <= result_sel;
            zero                 <= (result_sel == '0);
            jump_branch_addr_out <= jb_addr;
            data_mem_wr_data     <= rs2_data;
            reg_file_wr_addr_out <= reg_file_wr_addr_in;
            jump_branch_signal   <= fire ? jump_branch_signal_in : JUMP_BRANCH_NO;
            data_mem_wr_en       <= fire ? data_mem_wr_en_in : DATA_MEM_NO_WR;
            valid_out            <= fire;
        end
    end

endmodule

// File: doc/stage_execute.md
STAGE_EXECUTE -- requirements
Module: stage_execute

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the datapath width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have inputs rs1_data, rs2_data, imm, pc, each WIDTH, the operands and immediate from the ID/EX register.
REQ-005 SHALL have inputs alu_op (AluOp), alu_src_imm (1), valid_in (1), flush (1), reg_file_wr_addr_in (5), jump_branch_signal_in (JumpBranchControl), data_mem_wr_en_in (DataMemWrControl).
REQ-006 SHALL have registered EX/MEM outputs alu_result_out (WIDTH), zero (1), jump_branch_addr_out (WIDTH), data_mem_wr_data (WIDTH), reg_file_wr_addr_out (5), jump_branch_signal (JumpBranchControl), data_mem_wr_en (DataMemWrControl), valid_out (1).
REQ-007 SHALL have output stall_out (1), combinational, holding PC and ID/EX upstream while high.

Function
REQ-008 SHALL select operand B as imm when alu_src_imm=1, else rs2_data.
REQ-009 SHALL implement ADD, SUB, AND, OR, XOR, SLL, SRL, SRA (shift amount B[4:0]), SLT, SLTU; results wrap modulo 2^WIDTH.
REQ-010 SHALL drive zero high when the registered result equals 0.
REQ-011 SHALL compute jump_branch_addr as (rs1_data+imm) with bit 0 cleared for JUMP_ALR, else pc+imm.
REQ-012 SHALL pass rs2_data to data_mem_wr_data and forward reg_file_wr_addr, jump_branch_signal and data_mem_wr_en unchanged.
REQ-013 SHALL register single-cycle ops with latency 1: valid_in high at edge N gives valid_out high after edge N.
REQ-014 SHALL load a bubble (valid_out=0, JUMP_BRANCH_NO, DATA_MEM_NO_WR, other fields don't-care) when valid_in=0.
REQ-015 SHALL, when multiply/divide is enabled, run FSM IDLE->BUSY->IDLE: a valid MUL/DIVU/REMU in IDLE latches operands, enters BUSY with count=0.
REQ-016 SHALL perform one shift-add or restoring-divide iteration per BUSY cycle, 32 iterations total.
REQ-017 SHALL hold stall_out high from the accept cycle through BUSY count 30 (32 cycles), low at count 31.
REQ-018 SHALL, on the count-31 edge, load the result with valid_out=1 and return to IDLE; bubbles are output during BUSY.
REQ-019 SHALL return all-ones for DIVU and the dividend for REMU when the divisor is zero.
REQ-020 SHALL, on flush at an edge, load a bubble, abort BUSY to IDLE, and drop stall_out in the next cycle; flush wins over a simultaneous accept or completion.

Reset
REQ-021 SHALL, while reset_n=0, force all registered outputs to 0, jump_branch_signal to JUMP_BRANCH_NO, data_mem_wr_en to DATA_MEM_NO_WR, FSM to IDLE, count to 0.
REQ-022 SHALL, on reset mid-BUSY, discard the operation; stall_out SHALL be 0 during reset.

Configuration
REQ-023 SHALL compile the MUL/DIVU/REMU unit and FSM only when MULDIV_EN is defined.
REQ-024 SHALL, without MULDIV_EN, treat MUL/DIVU/REMU as single-cycle ops with result 0 and stall_out tied to 0.

Structure
REQ-025 SHALL take AluOp, JumpBranchControl and DataMemWrControl from package_project_typedefs; AluOp codes are added there.
REQ-026 SHALL place the iterative unit in sub-module execute_muldiv (start, op, a, b -> busy, done, result).

Verification
REQ-027 ADD rs1=500, imm=50, alu_src_imm=1 -> after 1 edge alu_result_out=550, zero=0, valid_out=1.
REQ-028 SUB rs1=7, rs2=7, BRANCH_EQ, pc=0x100, imm=16 -> zero=1, jump_branch_addr_out=0x110.
REQ-029 JUMP_ALR rs1=0x201, imm=4 -> jump_branch_addr_out=0x204.
REQ-030 MULDIV_EN: DIVU 100/7 -> stall_out high 32 cycles, result 14 after 33 edges; REMU 100/0 -> 100; DIVU x/0 -> 0xFFFFFFFF.
REQ-031 MULDIV_EN: MUL 3*5 with flush at BUSY count 10 -> valid_out stays 0, stall_out low next cycle, FSM IDLE.
REQ-032 reset_n low mid-BUSY -> all outputs reset values immediately, stall_out=0.
